// File: rtl/ctrl_pkg.sv
// Shared control-path types and constants for the ID/EX control pipeline.
// Used by the opcode decoder and the pipelined control unit.
package ctrl_pkg;

    localparam int ALU_W = 2;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] FUNCT7_MUL = 7'b0000001;

    localparam logic [ALU_W-1:0] ALU_R  = 2'b10;
    localparam logic [ALU_W-1:0] ALU_I  = 2'b00;
    localparam logic [ALU_W-1:0] ALU_S  = 2'b01;
    localparam logic [ALU_W-1:0] ALU_SB = 2'b11;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_read;
        logic             mem_write;
        logic             alu_src;
        logic             branch;
        logic             mul_op;
        logic [ALU_W-1:0] alu_op;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '{
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        alu_src:    1'b0,
        branch:     1'b0,
        mul_op:     1'b0,
        alu_op:     ALU_R
    };

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } mul_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode/funct7 decoder producing one control bundle.
// Kept standalone so single-cycle variants can reuse it unchanged.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int MUL_EN = 1
) (
    input  logic [6:0]   op,
    input  logic [6:0]   funct7,
    output ctrl_bundle_t ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_SB;
        case (op)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_R;
                ctrl.mul_op    = (MUL_EN != 0) && (funct7 == FUNCT7_MUL);
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_I;
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_I;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_S;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SB;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: registers decoded controls into ID/EX, detects
// load-use hazards and holds EX while a multi-cycle MUL is in flight.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int MUL_EN  = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [6:0]         Op_i,
    input  logic [6:0]         Funct7_i,
    input  logic [REG_AW-1:0]  RS1addr_i,
    input  logic [REG_AW-1:0]  RS2addr_i,
    input  logic [REG_AW-1:0]  RDaddr_i,
    input  logic               Flush_i,
    output logic               RegWrite_o,
    output logic               MemtoReg_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               ALUSrc_o,
    output logic               Branch_o,
    output logic               MulOp_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic [REG_AW-1:0]  RDaddr_o,
    output logic               Stall_o,
    output logic               MulBusy_o
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    ctrl_bundle_t      dec;
    ctrl_bundle_t      ex_q, ex_nx;
    logic [REG_AW-1:0] rd_q, rd_nx;
    mul_state_t        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              hz;

    ctrl_decode #(.MUL_EN(MUL_EN)) u_decode (
        .op     (Op_i),
        .funct7 (Funct7_i),
        .ctrl   (dec)
    );

    assign hz = ex_q.mem_read && (rd_q != '0) &&
                ((rd_q == RS1addr_i) || (rd_q == RS2addr_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ex_q  <= BUBBLE;
            rd_q  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ex_q  <= ex_nx;
            rd_q  <= rd_nx;
        end
    end

    // While BUSY the ID instruction is re-presented, so a flush there is moot.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ex_nx    = ex_q;
        rd_nx    = rd_q;
        if (state == ST_BUSY) begin
            cnt_nx = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state_nx = ST_IDLE;
            end
        end else if (Flush_i || hz) begin
            ex_nx = BUBBLE;
            rd_nx = '0;
        end else begin
            ex_nx = dec;
            rd_nx = RDaddr_i;
            if (dec.mul_op && (MUL_LAT > 1)) begin
                state_nx = ST_BUSY;
                cnt_nx   = CNT_W'(MUL_LAT - 1);
            end
        end
    end

    assign RegWrite_o = ex_q.reg_write;
    assign MemtoReg_o = ex_q.mem_to_reg;
    assign MemRead_o  = ex_q.mem_read;
    assign MemWrite_o = ex_q.mem_write;
    assign ALUSrc_o   = ex_q.alu_src;
    assign Branch_o   = ex_q.branch;
    assign MulOp_o    = ex_q.mul_op;
    assign ALUOp_o    = ALUOP_W'(ex_q.alu_op);
    assign RDaddr_o   = rd_q;
    assign MulBusy_o  = (state == ST_BUSY);
    assign Stall_o    = (state == ST_BUSY) || hz;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Self-checking bench for ctrl_pipe_unit: vector table, hand-built MUL/flush/reset
// sequences, and randomized traffic compared against a behavioural model.
module tb_ctrl_pipe_unit;

    localparam int MUL_LAT = 4;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_IMM = 7'b0010011;
    localparam logic [6:0] T_LD  = 7'b0000011;
    localparam logic [6:0] T_ST  = 7'b0100011;
    localparam logic [6:0] T_BR  = 7'b1100011;
    localparam logic [6:0] T_BAD = 7'b1111111;
    localparam logic [6:0] F7_MUL = 7'b0000001;
    localparam logic [8:0] V_BUB = 9'b000000010;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [6:0] Op_i = '0, Funct7_i = '0;
    logic [4:0] RS1addr_i = '0, RS2addr_i = '0, RDaddr_i = '0;
    logic       Flush_i = 1'b0;

    logic       RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o, MulOp_o;
    logic [1:0] ALUOp_o;
    logic [4:0] RDaddr_o;
    logic       Stall_o, MulBusy_o;

    logic       rw2, mtr2, mr2, mw2, src2, br2, mul2;
    logic [1:0] alu2;
    logic [4:0] rd2;
    logic       stall2, busy2;

    logic [8:0] ctl_vec, ctl_vec2;

    int checks = 0;
    int failures = 0;

    logic [8:0] m_ctl;
    logic [4:0] m_rd;
    int         m_busy_left;

    typedef struct {
        logic [6:0] op;
        logic [6:0] f7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       fl;
        logic       exp_stall;
        logic [8:0] exp_ctl;
        logic [4:0] exp_rd;
    } vec_t;

    vec_t vecs[13];

    ctrl_pipe_unit #(.ALUOP_W(2), .REG_AW(5), .MUL_LAT(MUL_LAT), .MUL_EN(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .Op_i(Op_i), .Funct7_i(Funct7_i),
        .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i), .Flush_i(Flush_i),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o), .MulOp_o(MulOp_o),
        .ALUOp_o(ALUOp_o), .RDaddr_o(RDaddr_o), .Stall_o(Stall_o), .MulBusy_o(MulBusy_o)
    );

    ctrl_pipe_unit #(.ALUOP_W(2), .REG_AW(5), .MUL_LAT(MUL_LAT), .MUL_EN(0)) dut_nomul (
        .clk_i(clk), .rst_i(rst_i), .Op_i(Op_i), .Funct7_i(Funct7_i),
        .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i), .Flush_i(Flush_i),
        .RegWrite_o(rw2), .MemtoReg_o(mtr2), .MemRead_o(mr2),
        .MemWrite_o(mw2), .ALUSrc_o(src2), .Branch_o(br2), .MulOp_o(mul2),
        .ALUOp_o(alu2), .RDaddr_o(rd2), .Stall_o(stall2), .MulBusy_o(busy2)
    );

    assign ctl_vec  = {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o, MulOp_o, ALUOp_o};
    assign ctl_vec2 = {rw2, mtr2, mr2, mw2, src2, br2, mul2, alu2};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference decode: {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,Branch,MulOp,ALUOp}
    function automatic logic [8:0] refDecode(input logic [6:0] op, input logic [6:0] f7);
        case (op)
            T_R:     return {6'b100000, (f7 == F7_MUL), 2'b10};
            T_IMM:   return 9'b100010000;
            T_LD:    return 9'b111010000;
            T_ST:    return 9'b000110001;
            T_BR:    return 9'b000001011;
            default: return 9'b000000011;
        endcase
    endfunction

    function automatic logic modelHz();
        return m_ctl[6] && (m_rd != 0) && ((m_rd == RS1addr_i) || (m_rd == RS2addr_i));
    endfunction

    task automatic modelReset();
        m_ctl = V_BUB;
        m_rd = '0;
        m_busy_left = 0;
    endtask

    task automatic modelEdge();
        if (m_busy_left > 0) begin
            m_busy_left--;
        end else if (Flush_i || modelHz()) begin
            m_ctl = V_BUB;
            m_rd = '0;
        end else begin
            m_ctl = refDecode(Op_i, Funct7_i);
            m_rd = RDaddr_i;
            if (m_ctl[2] && MUL_LAT > 1) m_busy_left = MUL_LAT - 1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 with Stall_o sampled mid-cycle.
    task automatic applyStimulus(input logic [6:0] op, input logic [6:0] f7, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd, input logic fl,
                                 output logic stall_seen);
        Op_i = op; Funct7_i = f7; RS1addr_i = rs1; RS2addr_i = rs2; RDaddr_i = rd; Flush_i = fl;
        #2;
        stall_seen = Stall_o;
        checkOutput("model_stall", 32'(Stall_o), 32'((m_busy_left > 0) || modelHz()));
        checkOutput("model_busy", 32'(MulBusy_o), 32'(m_busy_left > 0));
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("model_ctl", 32'(ctl_vec), 32'(m_ctl));
        checkOutput("model_rd", 32'(RDaddr_o), 32'(m_rd));
    endtask

    initial begin
        logic s;
        int   stall_cnt;
        logic [6:0] rop, rf7;

        vecs[0]  = '{T_LD,  7'd0, 5'd1, 5'd2, 5'd5,  1'b0, 1'b0, 9'b111010000, 5'd5};
        vecs[1]  = '{T_ST,  7'd0, 5'd6, 5'd7, 5'd9,  1'b0, 1'b0, 9'b000110001, 5'd9};
        vecs[2]  = '{T_BAD, 7'd0, 5'd1, 5'd1, 5'd4,  1'b0, 1'b0, 9'b000000011, 5'd4};
        vecs[3]  = '{T_LD,  7'd0, 5'd1, 5'd2, 5'd3,  1'b0, 1'b0, 9'b111010000, 5'd3};
        vecs[4]  = '{T_R,   7'd0, 5'd3, 5'd8, 5'd10, 1'b0, 1'b1, V_BUB,        5'd0};
        vecs[5]  = '{T_R,   7'd0, 5'd3, 5'd8, 5'd10, 1'b0, 1'b0, 9'b100000010, 5'd10};
        vecs[6]  = '{T_LD,  7'd0, 5'd2, 5'd2, 5'd0,  1'b0, 1'b0, 9'b111010000, 5'd0};
        vecs[7]  = '{T_R,   7'd0, 5'd0, 5'd0, 5'd11, 1'b0, 1'b0, 9'b100000010, 5'd11};
        vecs[8]  = '{T_IMM, 7'd0, 5'd4, 5'd4, 5'd12, 1'b0, 1'b0, 9'b100010000, 5'd12};
        vecs[9]  = '{T_BR,  7'd0, 5'd1, 5'd2, 5'd13, 1'b1, 1'b0, V_BUB,        5'd0};
        vecs[10] = '{T_LD,  7'd0, 5'd1, 5'd2, 5'd7,  1'b0, 1'b0, 9'b111010000, 5'd7};
        vecs[11] = '{T_BR,  7'd0, 5'd1, 5'd7, 5'd1,  1'b1, 1'b1, V_BUB,        5'd0};
        vecs[12] = '{T_BR,  7'd0, 5'd1, 5'd7, 5'd1,  1'b0, 1'b0, 9'b000001011, 5'd1};

        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ctl", 32'(ctl_vec), 32'(V_BUB));
        checkOutput("reset_rd", 32'(RDaddr_o), 32'd0);
        checkOutput("reset_stall", 32'(Stall_o), 32'd0);
        checkOutput("reset_busy", 32'(MulBusy_o), 32'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].op, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].fl, s);
            checkOutput($sformatf("vec%0d_stall", i), 32'(s), 32'(vecs[i].exp_stall));
            checkOutput($sformatf("vec%0d_ctl", i), 32'(ctl_vec), 32'(vecs[i].exp_ctl));
            checkOutput($sformatf("vec%0d_rd", i), 32'(RDaddr_o), 32'(vecs[i].exp_rd));
        end

        // MUL occupancy, and the MUL_EN=0 instance treating it as plain R-type
        applyStimulus(T_R, F7_MUL, 5'd1, 5'd2, 5'd13, 1'b0, s);
        checkOutput("mul_load_ctl", 32'(ctl_vec), 32'(9'b100000110));
        checkOutput("mul_load_busy", 32'(MulBusy_o), 32'd1);
        checkOutput("nomul_ctl", 32'(ctl_vec2), 32'(9'b100000010));
        checkOutput("nomul_busy", 32'(busy2), 32'd0);
        checkOutput("nomul_stall", 32'(stall2), 32'd0);
        stall_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(T_R, 7'd0, 5'd1, 5'd2, 5'd14, 1'b0, s);
            if (s) stall_cnt++;
            if (i < 4) checkOutput("mul_hold_rd", 32'(RDaddr_o), 32'd13);
        end
        checkOutput("mul_stall_cycles", 32'(stall_cnt), 32'd3);
        checkOutput("after_mul_rd", 32'(RDaddr_o), 32'd14);
        checkOutput("after_mul_busy", 32'(MulBusy_o), 32'd0);

        // Flush while BUSY is ignored; flush of a MUL in IDLE never enters BUSY
        applyStimulus(T_R, F7_MUL, 5'd1, 5'd2, 5'd15, 1'b0, s);
        applyStimulus(T_IMM, 7'd0, 5'd1, 5'd2, 5'd16, 1'b1, s);
        checkOutput("busy_flush_rd", 32'(RDaddr_o), 32'd15);
        checkOutput("busy_flush_mul", 32'(MulOp_o), 32'd1);
        applyStimulus(T_IMM, 7'd0, 5'd1, 5'd2, 5'd16, 1'b0, s);
        applyStimulus(T_IMM, 7'd0, 5'd1, 5'd2, 5'd16, 1'b0, s);
        applyStimulus(T_R, F7_MUL, 5'd1, 5'd2, 5'd17, 1'b1, s);
        checkOutput("idle_flush_ctl", 32'(ctl_vec), 32'(V_BUB));
        checkOutput("idle_flush_busy", 32'(MulBusy_o), 32'd0);
        applyStimulus(T_IMM, 7'd0, 5'd1, 5'd2, 5'd18, 1'b0, s);
        checkOutput("idle_flush_nostall", 32'(s), 32'd0);

        // Back-to-back MULs
        applyStimulus(T_R, F7_MUL, 5'd1, 5'd2, 5'd19, 1'b0, s);
        for (int i = 0; i < 4; i++) applyStimulus(T_R, F7_MUL, 5'd1, 5'd2, 5'd20, 1'b0, s);
        checkOutput("b2b_rd", 32'(RDaddr_o), 32'd20);
        checkOutput("b2b_busy", 32'(MulBusy_o), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(T_IMM, 7'd0, 5'd1, 5'd2, 5'd21, 1'b0, s);

        // Asynchronous reset while BUSY
        applyStimulus(T_R, F7_MUL, 5'd1, 5'd2, 5'd22, 1'b0, s);
        applyStimulus(T_IMM, 7'd0, 5'd1, 5'd2, 5'd23, 1'b0, s);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("async_rst_ctl", 32'(ctl_vec), 32'(V_BUB));
        checkOutput("async_rst_rd", 32'(RDaddr_o), 32'd0);
        checkOutput("async_rst_stall", 32'(Stall_o), 32'd0);
        checkOutput("async_rst_busy", 32'(MulBusy_o), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: rop = T_R;
                1: rop = T_IMM;
                2: rop = T_LD;
                3: rop = T_ST;
                4: rop = T_BR;
                default: rop = 7'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: rf7 = 7'd0;
                1: rf7 = F7_MUL;
                default: rf7 = 7'($urandom);
            endcase
            applyStimulus(rop, rf7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
Pipelined successor to the single-cycle opcode decoder. It decodes RV32 opcodes, registers the control bundle into the ID/EX stage, detects load-use hazards, and manages multi-cycle MUL occupancy of EX with a counter FSM. It sits between the ID stage (opcode/register fields) and the EX stage; its Stall_o output gates the PC and IF/ID writes.

Parameters:
ALUOP_W, 2, width of ALUOp encoding
REG_AW, 5, register-address width
MUL_LAT, 4, EX cycles occupied by a MUL; legal range >=1; 1 means no extra stall
MUL_EN, 1, 0 treats funct7=0000001 R-type as plain R-type (MulOp_o never set)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
Op_i  in  7  ID opcode
Funct7_i  in  7  ID funct7
RS1addr_i  in  REG_AW  ID rs1
RS2addr_i  in  REG_AW  ID rs2
RDaddr_i  in  REG_AW  ID rd
Flush_i  in  1  insert bubble into ID/EX (taken branch resolved in ID)
RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o, MulOp_o  out  1 each  registered EX-stage controls
ALUOp_o  out  ALUOP_W  registered EX-stage ALU class
RDaddr_o  out  REG_AW  registered EX-stage rd
Stall_o  out  1  combinational; hold PC and IF/ID
MulBusy_o  out  1  registered; EX occupied by an in-flight MUL

Behaviour:
- Decode table (combinational, next-state of ID/EX). Signal order is RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, then ALUOp:
  - 0110011 R: 1,0,0,0,0,0, ALUOp 10. MulOp=1 iff MUL_EN && Funct7_i==0000001.
  - 0010011 I-arith: 1,0,0,0,1,0, ALUOp 00.
  - 0000011 load: 1,1,1,0,1,0, ALUOp 00.
  - 0100011 store: 0,0,0,1,1,0, ALUOp 01.
  - 1100011 branch: 0,0,0,0,0,1, ALUOp 11.
  - Any other opcode, including 0000000: all controls 0, ALUOp 11.
- Bubble value: all 1-bit controls 0, ALUOp 10, RDaddr 0.
- Reset: ID/EX register holds the bubble value; FSM in IDLE; counter 0; MulBusy_o=0.
- Load-use hazard: hz = MemRead_o && RDaddr_o!=0 && (RDaddr_o==RS1addr_i || RDaddr_o==RS2addr_i).
- FSM states:
  - IDLE: if the ID/EX register loads a decoded MUL and MUL_LAT>1, go to BUSY with cnt=MUL_LAT-1.
  - BUSY: cnt decrements each cycle. When cnt==1, return to IDLE next edge. MulBusy_o=1 iff state==BUSY.
- Stall_o = (state==BUSY) || hz.
- ID/EX update priority, evaluated per rising edge:
  1. BUSY: hold all registered outputs; Flush_i is ignored because the ID instruction is re-presented.
  2. Flush_i: load the bubble value.
  3. hz: load the bubble value; a one-cycle stall.
  4. Otherwise: load the decoded value.
- Latency: 1 cycle from ID inputs to registered outputs. A MUL holds EX for exactly MUL_LAT cycles, with Stall_o high for MUL_LAT-1 of them.
- Back-to-back MULs: the second MUL loads on the cycle BUSY exits and restarts the count.
- A MUL that is flushed or bubbled never enters BUSY.
- Reset asserted mid-BUSY: immediate return to IDLE and bubble; Stall_o drops asynchronously.
- Counter width: $clog2(MUL_LAT+1); no wrap is possible.

Decomposition:
- Shared package ctrl_pkg: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH), ALUOp encodings (ALU_R=10, ALU_I=00, ALU_S=01, ALU_SB=11), FUNCT7_MUL, a ctrl_bundle_t struct, and the BUBBLE constant.
- One sub-module, ctrl_decode: a pure combinational opcode/funct7 to ctrl_bundle_t decoder, reused by any later single-cycle variant.

Test Plan:
- Reset mid-stream: rst_i=1 asynchronously while BUSY -> all controls 0, ALUOp 10, Stall_o=0, MulBusy_o=0 without waiting for a clock edge.
- Decode sweep: Op_i=0000011, rd=5 -> next cycle RegWrite=1, MemtoReg=1, MemRead=1, ALUSrc=1, ALUOp=00, RDaddr_o=5. Op_i=0100011 -> MemWrite=1, ALUOp=01. Op_i=1111111 -> all 0, ALUOp=11.
- Load-use: load rd=3, then add with rs1=3 -> Stall_o=1 for 1 cycle, ID/EX=bubble, add loads on the following edge. Repeat with rd=0 -> no stall.
- MUL, MUL_LAT=4: R-type funct7=0000001 -> MulOp_o=1, MulBusy_o=1 for 3 cycles, Stall_o=1 for 3 cycles, outputs held, next instruction loads on the 4th edge. With MUL_EN=0 -> no stall, MulOp_o=0.
- Flush during BUSY vs IDLE: Flush_i=1 while BUSY -> outputs unchanged. Flush_i=1 in IDLE with a MUL in ID -> bubble loaded, no BUSY entry.
- Simultaneous flush and hz: both high -> bubble loaded, Stall_o=1, exactly one bubble cycle.
